tdm_demux4: RTL and testbench

Four-slot time-division demultiplexer: the receive end of the 4-to-1 selector path. It drives the two select lines of an upstream 4-to-1 data selector, samples the selector's single-bit output once per slot, and reassembles the four bits into a registered parallel word with a frame-valid strobe. It also provides an active-low one-hot slot decode in the style of a 2-to-4 decoder, and supports frame realignment through a sync input.

---
 rtl/tdm_demux4_if.sv | 24 ++
 rtl/tdm_demux4.sv | 127 ++++++++++++
 tb/tb_tdm_demux4.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: signal bundle between the TDM receive controller and its environment.
//   master : environment side (drives en, sync, din; observes selects, decode, frame outputs)
//   slave  : controller side (consumes en, sync, din; drives sel0/sel1, y_n, q, frame_valid, sync_err)
interface tdm_demux4_if;
   logic       en;
   logic       sync;
   logic       din;
   logic       sel0;
   logic       sel1;
   logic [3:0] y_n;
   logic [3:0] q;
   logic       frame_valid;
   logic       sync_err;

   modport master (
      output en, sync, din,
      input  sel0, sel1, y_n, q, frame_valid, sync_err
   );

   modport slave (
      input  en, sync, din,
      output sel0, sel1, y_n, q, frame_valid, sync_err
   );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot time-division demultiplexer. Steps the select lines of an
// upstream 4-to-1 selector, samples its serial output once per slot on the last
// cycle of the slot, and reassembles the four bits into a registered word.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   tdm.en          run enable
//   tdm.sync        frame realign request (forces slot 0)
//   tdm.din         serial data from the upstream selector
//   tdm.sel0/sel1   registered slot select to the upstream selector
//   tdm.y_n         registered active-low one-hot slot decode, 1111 when idle
//   tdm.q           last complete frame, q[i] = slot-i bit
//   tdm.frame_valid one-cycle pulse when q updates
//   tdm.sync_err    one-cycle pulse after a sync that missed the frame boundary
//
// state | meaning
// IDLE  | selects parked at 00, decode all-ones, waiting for en
// RUN   | cycling slots 0..3, each SLOT_CYCLES long, sampling on the last cycle
module tdm_demux4 #(
   parameter int SLOT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux4_if.slave  tdm
);
   localparam int DIV_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       shadow_q, shadow_d;
   logic [3:0]       q_q, q_d;
   logic [3:0]       y_n_q, y_n_d;
   logic             fv_q, fv_d;
   logic             serr_q, serr_d;
   logic             sample;
   logic             wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         slot_q   <= 2'd0;
         div_q    <= '0;
         shadow_q <= 3'b000;
         q_q      <= 4'b0000;
         y_n_q    <= 4'b1111;
         fv_q     <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         q_q      <= q_d;
         y_n_q    <= y_n_d;
         fv_q     <= fv_d;
         serr_q   <= serr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      q_d      = q_q;
      fv_d     = 1'b0;
      serr_d   = 1'b0;
      sample   = (div_q == DIV_LAST);
      wrap     = sample && (slot_q == 2'd3);

      case (state_q)
         IDLE: begin
            if (tdm.en) begin
               state_d = RUN;
               slot_d  = 2'd0;
               div_d   = '0;
            end
         end
         RUN: begin
            // A frame that reaches its slot-3 sample always completes, even when
            // the same edge also leaves RUN or realigns.
            if (wrap) begin
               q_d  = {tdm.din, shadow_q};
               fv_d = 1'b1;
            end
            if (!tdm.en) begin
               state_d  = IDLE;
               slot_d   = 2'd0;
               div_d    = '0;
               shadow_d = 3'b000;
            end else if (tdm.sync) begin
               slot_d   = 2'd0;
               div_d    = '0;
               shadow_d = 3'b000;
               serr_d   = !wrap;
            end else if (sample) begin
               div_d  = '0;
               slot_d = slot_q + 2'd1;
               case (slot_q)
                  2'd0:    shadow_d[0] = tdm.din;
                  2'd1:    shadow_d[1] = tdm.din;
                  2'd2:    shadow_d[2] = tdm.din;
                  default: shadow_d    = shadow_q;
               endcase
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Decode is registered alongside the selects so both move on the same edge.
      y_n_d = (state_d == RUN) ? ~(4'b0001 << slot_d) : 4'b1111;
   end

   assign tdm.sel0        = slot_q[0];
   assign tdm.sel1        = slot_q[1];
   assign tdm.y_n         = y_n_q;
   assign tdm.q           = q_q;
   assign tdm.frame_valid = fv_q;
   assign tdm.sync_err    = serr_q;
endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src;
   logic [3:0] src1;
   int         n_cmp = 0;
   int         n_bad = 0;

   tdm_demux4_if tdm ();
   tdm_demux4_if tdm1 ();

   // Behavioural upstream 4-to-1 selectors.
   assign tdm.din  = src[{tdm.sel1, tdm.sel0}];
   assign tdm1.din = src1[{tdm1.sel1, tdm1.sel0}];

   tdm_demux4 #(.SLOT_CYCLES(S)) u_dut  (.clk(clk), .rst(rst), .tdm(tdm));
   tdm_demux4 #(.SLOT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .tdm(tdm1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tdm.en = 1'b0;
      tdm.sync = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tdm.en = 1'b0;
      tdm.sync = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tdm.sync = (i >= 5);
         tick();
         n_cmp++;
         if ({tdm.sel1, tdm.sel0, tdm.y_n, tdm.q, tdm.frame_valid, tdm.sync_err} !== 12'b00_1111_0000_0_0) begin
            n_bad++;
            $display("FAIL reset cyc %0d: got sel=%b%b y_n=%b q=%b fv=%b serr=%b, want sel=00 y_n=1111 q=0000 fv=0 serr=0",
                     i, tdm.sel1, tdm.sel0, tdm.y_n, tdm.q, tdm.frame_valid, tdm.sync_err);
         end
      end
      tdm.sync = 1'b0;
   endtask

   // Single frame, continuous data, then random frames; expectations from slot arithmetic.
   task automatic test_frames();
      logic [3:0] exp_q, cur;
      int slot;
      bit exp_fv;
      do_reset();
      exp_q = 4'b0000;
      cur = 4'b1101;
      src = cur;
      tdm.en = 1'b1;
      for (int e = 0; e <= 56; e++) begin
         tick();
         slot = (e / S) % 4;
         exp_fv = (e > 0) && (e % (4 * S) == 0);
         if (exp_fv) exp_q = cur;
         n_cmp++;
         if ({tdm.sel1, tdm.sel0} !== 2'(slot) || tdm.y_n !== ~(4'b0001 << slot)) begin
            n_bad++;
            $display("FAIL frames_slot edge %0d: got sel=%b%b y_n=%b, want sel=%0d y_n=%b",
                     e, tdm.sel1, tdm.sel0, tdm.y_n, slot, ~(4'b0001 << slot));
         end
         n_cmp++;
         if (tdm.frame_valid !== exp_fv || tdm.q !== exp_q || tdm.sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL frames_data edge %0d: got fv=%b q=%b serr=%b, want fv=%b q=%b serr=0",
                     e, tdm.frame_valid, tdm.q, tdm.sync_err, exp_fv, exp_q);
         end
         if (exp_fv) begin
            cur = (e == 4 * S) ? 4'b0110 : 4'($urandom);
            src = cur;
         end
      end
      tdm.en = 1'b0;
   endtask

   task automatic test_mid_sync();
      logic [3:0] a, c;
      do_reset();
      a = 4'($urandom);
      src = a;
      tdm.en = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         tick();
         if (e == 8) src = 4'($urandom);
      end
      // slot 2, div 0 now; sync is seen at edge 13
      tdm.sync = 1'b1;
      tick();
      tdm.sync = 1'b0;
      n_cmp++;
      if (tdm.sync_err !== 1'b1 || tdm.frame_valid !== 1'b0 || tdm.q !== a ||
          {tdm.sel1, tdm.sel0} !== 2'b00 || tdm.y_n !== 4'b1110) begin
         n_bad++;
         $display("FAIL mid_sync: got serr=%b fv=%b q=%b sel=%b%b y_n=%b, want serr=1 fv=0 q=%b sel=00 y_n=1110",
                  tdm.sync_err, tdm.frame_valid, tdm.q, tdm.sel1, tdm.sel0, tdm.y_n, a);
      end
      c = 4'($urandom);
      src = c;
      for (int e = 14; e <= 21; e++) begin
         tick();
         n_cmp++;
         if (tdm.sync_err !== 1'b0 || tdm.frame_valid !== (e == 21) || tdm.q !== ((e == 21) ? c : a)) begin
            n_bad++;
            $display("FAIL mid_sync_realign edge %0d: got serr=%b fv=%b q=%b, want serr=0 fv=%b q=%b",
                     e, tdm.sync_err, tdm.frame_valid, tdm.q, (e == 21), (e == 21) ? c : a);
         end
      end
      tdm.en = 1'b0;
   endtask

   task automatic test_sync_wrap();
      logic [3:0] a, b;
      do_reset();
      a = 4'($urandom);
      src = a;
      tdm.en = 1'b1;
      for (int e = 0; e <= 7; e++) tick();
      // slot 3, div 1: edge 8 is the natural wrap
      tdm.sync = 1'b1;
      tick();
      tdm.sync = 1'b0;
      n_cmp++;
      if (tdm.frame_valid !== 1'b1 || tdm.q !== a || tdm.sync_err !== 1'b0 || tdm.y_n !== 4'b1110) begin
         n_bad++;
         $display("FAIL sync_wrap: got fv=%b q=%b serr=%b y_n=%b, want fv=1 q=%b serr=0 y_n=1110",
                  tdm.frame_valid, tdm.q, tdm.sync_err, tdm.y_n, a);
      end
      b = 4'($urandom);
      src = b;
      for (int e = 9; e <= 16; e++) begin
         tick();
         n_cmp++;
         if (tdm.sync_err !== 1'b0 || tdm.frame_valid !== (e == 16) || tdm.q !== ((e == 16) ? b : a)) begin
            n_bad++;
            $display("FAIL sync_wrap_next edge %0d: got serr=%b fv=%b q=%b, want serr=0 fv=%b q=%b",
                     e, tdm.sync_err, tdm.frame_valid, tdm.q, (e == 16), (e == 16) ? b : a);
         end
      end
      tdm.en = 1'b0;
   endtask

   task automatic test_en_drop();
      logic [3:0] a, c, d;
      do_reset();
      a = 4'($urandom);
      src = a;
      tdm.en = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         tick();
         if (e == 8) src = 4'($urandom);
      end
      // slot 1, div 0; en low seen at edge 11, with sync also high to show en wins
      tdm.en = 1'b0;
      tdm.sync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (tdm.y_n !== 4'b1111 || {tdm.sel1, tdm.sel0} !== 2'b00 || tdm.q !== a ||
             tdm.frame_valid !== 1'b0 || tdm.sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop cyc %0d: got y_n=%b sel=%b%b q=%b fv=%b serr=%b, want y_n=1111 sel=00 q=%b fv=0 serr=0",
                     i, tdm.y_n, tdm.sel1, tdm.sel0, tdm.q, tdm.frame_valid, tdm.sync_err, a);
         end
      end
      tdm.sync = 1'b0;
      c = 4'($urandom);
      src = c;
      tdm.en = 1'b1;
      for (int j = 0; j <= 8; j++) begin
         tick();
         n_cmp++;
         if (tdm.frame_valid !== (j == 8) || tdm.q !== ((j == 8) ? c : a)) begin
            n_bad++;
            $display("FAIL reenable j %0d: got fv=%b q=%b, want fv=%b q=%b",
                     j, tdm.frame_valid, tdm.q, (j == 8), (j == 8) ? c : a);
         end
      end
      d = 4'($urandom);
      src = d;
      for (int j = 9; j <= 15; j++) tick();
      // en falls on a slot-3 sample edge: the frame still completes
      tdm.en = 1'b0;
      tick();
      n_cmp++;
      if (tdm.frame_valid !== 1'b1 || tdm.q !== d || tdm.y_n !== 4'b1111 || {tdm.sel1, tdm.sel0} !== 2'b00) begin
         n_bad++;
         $display("FAIL en_drop_wrap: got fv=%b q=%b y_n=%b sel=%b%b, want fv=1 q=%b y_n=1111 sel=00",
                  tdm.frame_valid, tdm.q, tdm.y_n, tdm.sel1, tdm.sel0, d);
      end
      tick();
      n_cmp++;
      if (tdm.frame_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL en_drop_wrap_pulse: got fv=%b, want fv=0", tdm.frame_valid);
      end
   endtask

   task automatic test_rst_mid();
      logic [3:0] c;
      do_reset();
      src = 4'($urandom) | 4'b1000;
      tdm.en = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         tick();
         if (e == 8) src = 4'($urandom);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({tdm.sel1, tdm.sel0, tdm.y_n, tdm.q, tdm.frame_valid, tdm.sync_err} !== 12'b00_1111_0000_0_0) begin
         n_bad++;
         $display("FAIL rst_mid: got sel=%b%b y_n=%b q=%b fv=%b serr=%b, want sel=00 y_n=1111 q=0000 fv=0 serr=0",
                  tdm.sel1, tdm.sel0, tdm.y_n, tdm.q, tdm.frame_valid, tdm.sync_err);
      end
      c = 4'($urandom);
      src = c;
      for (int j = 0; j <= 8; j++) begin
         tick();
         n_cmp++;
         if (tdm.frame_valid !== (j == 8) || tdm.q !== ((j == 8) ? c : 4'b0000) ||
             tdm.y_n !== ~(4'b0001 << ((j / S) % 4))) begin
            n_bad++;
            $display("FAIL rst_restart j %0d: got fv=%b q=%b y_n=%b, want fv=%b q=%b y_n=%b",
                     j, tdm.frame_valid, tdm.q, tdm.y_n, (j == 8), (j == 8) ? c : 4'b0000,
                     ~(4'b0001 << ((j / S) % 4)));
         end
      end
      tdm.en = 1'b0;
   endtask

   task automatic test_slot1();
      do_reset();
      src1 = 4'($urandom);
      tdm1.en = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         tick();
         n_cmp++;
         if ({tdm1.sel1, tdm1.sel0} !== 2'(e % 4) || tdm1.frame_valid !== (e > 0 && e % 4 == 0) ||
             tdm1.q !== ((e >= 4) ? src1 : 4'b0000) || tdm1.y_n !== ~(4'b0001 << (e % 4))) begin
            n_bad++;
            $display("FAIL slot1 edge %0d: got sel=%b%b fv=%b q=%b y_n=%b, want sel=%0d fv=%b q=%b y_n=%b",
                     e, tdm1.sel1, tdm1.sel0, tdm1.frame_valid, tdm1.q, tdm1.y_n, e % 4,
                     (e > 0 && e % 4 == 0), (e >= 4) ? src1 : 4'b0000, ~(4'b0001 << (e % 4)));
         end
      end
      tdm1.en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      src = 4'b0000;
      src1 = 4'b0000;
      tdm.en = 1'b0;
      tdm.sync = 1'b0;
      tdm1.en = 1'b0;
      tdm1.sync = 1'b0;
      test_reset();
      test_frames();
      test_mid_sync();
      test_sync_wrap();
      test_en_drop();
      test_rst_mid();
      test_slot1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
